gb_apu_frame_sequencer: RTL and testbench
=========================================

// Module: gb_apu_frame_sequencer
// PURPOSE
//   Generates the APU frame-sequencer tick strobes that drive the channel function units:
//   clk_length_ctr (256 Hz), clk_sweep (128 Hz) and clk_vol_env (64 Hz).
//   Paced by the falling edge of the DIV-APU bit (external mode) or by an internal prescaler.
//   Its strobes are consumed directly as clk_* inputs by the length, sweep and envelope
//   function units, for example gb_apu_function_envelope.clk_vol_env.
// PARAMETERS
//   INTERNAL_DIV  0     1: ignore div_apu_bit and use the internal prescaler; 0: use div_apu_bit edges
//   PRESCALE      8192  clk cycles per sequencer event in internal mode (4.194304 MHz / 512 Hz)
//   PS_W          13    prescaler counter width; must satisfy 2**PS_W >= PRESCALE
// PORTS
//   clk             in   1  system clock
//   reset           in   1  asynchronous, active-high reset
//   apu_enable      in   1  NR52 bit 7 (APU power); low holds the sequencer cleared
//   div_apu_bit     in   1  DIV bit 4 (bit 5 in double speed); a 1->0 transition is one event
//   clk_length_ctr  out  1  one-cycle strobe: length counters tick
//   clk_sweep       out  1  one-cycle strobe: CH1 frequency sweep tick
//   clk_vol_env     out  1  one-cycle strobe: volume envelope tick
//   step            out  3  index of the NEXT step to execute, 0..7
// BEHAVIOUR
//   Reset (async): step=0, all strobes 0, prev_div=0, prescaler=0.
//   Event detect:
//     - external mode: event = prev_div & ~div_apu_bit, sampled at posedge clk; prev_div <= div_apu_bit every cycle.
//     - internal mode: prescaler counts 0..PRESCALE-1 while enabled; event fires on the cycle the count
//       equals PRESCALE-1, and the count then wraps to 0.
//   On an event with apu_enable=1, strobes are registered from the current step and step <= step+1 (mod 8, 7 wraps to 0):
//     step 0: length | 1: none | 2: length+sweep | 3: none
//     step 4: length | 5: none | 6: length+sweep | 7: envelope
//   Latency: a strobe is high for exactly the one clk cycle following the posedge at which the event is detected.
//     No event: all strobes 0.
//   Per 8 events: 4 length strobes, 2 sweep strobes, 1 envelope strobe, with length and sweep coincident on steps 2 and 6.
//   apu_enable=0:
//     - step=0, strobes forced 0 synchronously, prescaler held at 0.
//     - prev_div continues to track div_apu_bit, so re-enabling while the bit is low creates no spurious event.
//     - the first event after re-enable executes step 0.
//   div_apu_bit held high or held low: no events. Each 1->0 edge gives exactly one event, regardless of pulse width (>=1 cycle).
//   An edge coinciding with apu_enable going 0: the event is discarded and step=0.
//   Reset asserted mid-sequence: immediate return to reset values, including any strobe in flight.
//   Strobes never stretch: back-to-back events on consecutive cycles give strobes on consecutive cycles.
//   Outputs are registered only; there is no combinational path from inputs to outputs.
// TESTING
//   1. Reset, apu_enable=1, 8 div_apu_bit falling edges
//      -> length strobes after events 1,3,5,7; sweep after 3,7; vol_env after 8 only; step back at 0.
//   2. 64 falling edges -> exactly 32 length, 16 sweep and 8 vol_env strobes, each strobe 1 cycle wide.
//   3. After 5 events (step=5), drop apu_enable for 3 cycles, then re-enable
//      -> step=0, no strobe while disabled; the next event gives a length strobe only.
//   4. div_apu_bit held high for 100 cycles, then held low for 100 cycles -> exactly one event; step advances by 1.
//   5. Assert reset asynchronously between clock edges at step 7, on the strobe cycle
//      -> clk_vol_env=0 and step=0 before the next posedge.
//   6. INTERNAL_DIV=1, PRESCALE=16 -> events every 16 cycles;
//      clk_vol_env period is 128 cycles and clk_length_ctr period is 32 cycles; div_apu_bit toggling is ignored.

Source files
------------

// File: rtl/gb_apu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// gb_apu_frame_sequencer
//
// Generates the three Game Boy APU frame-sequencer tick strobes that pace
// the channel function units:
//   clk_length_ctr : 256 Hz, length counters
//   clk_sweep      : 128 Hz, CH1 frequency sweep
//   clk_vol_env    :  64 Hz, volume envelopes
//
// A sequencer event comes either from a falling edge of the DIV-APU bit
// (INTERNAL_DIV=0) or from an internal prescaler that fires once every
// PRESCALE clocks (INTERNAL_DIV=1). Each event executes the current step
// of an 8-step table, raises the matching strobes for one cycle, and
// advances the step index.
//
// Ports
//   clk             in   system clock
//   reset           in   asynchronous, active-high reset
//   apu_enable      in   APU power (NR52 bit 7); low holds the sequencer cleared
//   div_apu_bit     in   DIV bit 4 (bit 5 in double speed); 1->0 is one event
//   clk_length_ctr  out  one-cycle strobe, length counters tick
//   clk_sweep       out  one-cycle strobe, CH1 sweep tick
//   clk_vol_env     out  one-cycle strobe, volume envelope tick
//   step            out  index of the next step to execute (0..7); this is
//                        the sequencer state and doubles as its debug view
//
// Handshake: there is none; strobes are single-cycle pulses with no
// back-pressure and consumers must sample them on the cycle they are high.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module gb_apu_frame_sequencer #(
  parameter bit INTERNAL_DIV = 1'b0,
  parameter int PRESCALE     = 8192,
  parameter int PS_W         = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       div_apu_bit,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [2:0] step
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic            prev_div_q;
  logic [PS_W-1:0] ps_q,    ps_d;
  logic [2:0]      step_q,  step_d;
  logic            len_q,   len_d;
  logic            sweep_q, sweep_d;
  logic            env_q,   env_d;

  // -------------------------------------------------------------------------
  // Event detection
  // -------------------------------------------------------------------------
  logic ext_event;
  logic int_event;
  logic seq_event;

  // prev_div keeps tracking the pin even while the APU is off, so turning
  // the APU back on while the bit is already low cannot look like an edge.
  assign ext_event = prev_div_q & ~div_apu_bit;
  assign int_event = (ps_q == PS_LAST);
  assign seq_event = INTERNAL_DIV ? int_event : ext_event;

  // Prescaler: runs only in internal mode while powered, wraps after the
  // terminal count. Held at zero otherwise so re-enable restarts a full period.
  always_comb begin
    ps_d = ps_q;
    if (!INTERNAL_DIV || !apu_enable) begin
      ps_d = '0;
    end else if (int_event) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Step sequencer
  // -------------------------------------------------------------------------
  // Step table (the step being executed, not the one after):
  //   0: length  1: -  2: length+sweep  3: -
  //   4: length  5: -  6: length+sweep  7: envelope
  always_comb begin
    step_d  = step_q;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!apu_enable) begin
      // Powered off: an event on this cycle is dropped, not deferred.
      step_d = 3'd0;
    end else if (seq_event) begin
      step_d = step_q + 3'd1;  // 7 wraps to 0 by width
      case (step_q)
        3'd0:    len_d = 1'b1;
        3'd2:    begin len_d = 1'b1; sweep_d = 1'b1; end
        3'd4:    len_d = 1'b1;
        3'd6:    begin len_d = 1'b1; sweep_d = 1'b1; end
        3'd7:    env_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_div_q <= 1'b0;
      ps_q       <= '0;
      step_q     <= 3'd0;
      len_q      <= 1'b0;
      sweep_q    <= 1'b0;
      env_q      <= 1'b0;
    end else begin
      prev_div_q <= div_apu_bit;
      ps_q       <= ps_d;
      step_q     <= step_d;
      len_q      <= len_d;
      sweep_q    <= sweep_d;
      env_q      <= env_d;
    end
  end

  assign clk_length_ctr = len_q;
  assign clk_sweep      = sweep_q;
  assign clk_vol_env    = env_q;
  assign step           = step_q;

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gb_apu_frame_sequencer
//
// Drives one external-mode sequencer and one internal-mode sequencer
// (PRESCALE=16) from shared inputs. The reference model counts events since
// the last clear and derives the expected step and strobes from that count
// with modular arithmetic; outputs of both instances are compared to it on
// every falling clock edge. Directed sections pin the model with literal
// counts, steps and periods.
// ---------------------------------------------------------------------------
module tb_gb_apu_frame_sequencer;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk         = 1'b0;
  logic reset       = 1'b1;
  logic apu_enable  = 1'b0;
  logic div_apu_bit = 1'b0;

  always #5 clk = ~clk;

  logic       len_e, sweep_e, env_e;
  logic [2:0] step_e;
  logic       len_i, sweep_i, env_i;
  logic [2:0] step_i;

  gb_apu_frame_sequencer u_ext (
    .clk            (clk),
    .reset          (reset),
    .apu_enable     (apu_enable),
    .div_apu_bit    (div_apu_bit),
    .clk_length_ctr (len_e),
    .clk_sweep      (sweep_e),
    .clk_vol_env    (env_e),
    .step           (step_e)
  );

  gb_apu_frame_sequencer #(
    .INTERNAL_DIV (1'b1),
    .PRESCALE     (16),
    .PS_W         (4)
  ) u_int (
    .clk            (clk),
    .reset          (reset),
    .apu_enable     (apu_enable),
    .div_apu_bit    (div_apu_bit),
    .clk_length_ctr (len_i),
    .clk_sweep      (sweep_i),
    .clk_vol_env    (env_i),
    .step           (step_i)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: event counts since the last clear
  // -------------------------------------------------------------------------
  bit m_prev = 1'b0;   // last sampled div_apu_bit
  int m_cnt_e = 0;     // events executed by the external sequencer
  bit m_ev_e = 1'b0;   // external event executed at the last edge
  int m_ps = 0;        // cycles counted by the internal prescaler
  int m_cnt_i = 0;
  bit m_ev_i = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_prev = 1'b0; m_cnt_e = 0; m_ev_e = 1'b0;
        m_ps = 0; m_cnt_i = 0; m_ev_i = 1'b0;
      end else begin
        bit fall;
        fall   = m_prev && !div_apu_bit;
        m_prev = div_apu_bit;
        if (!apu_enable) begin
          m_cnt_e = 0; m_ev_e = 1'b0;
          m_ps = 0; m_cnt_i = 0; m_ev_i = 1'b0;
        end else begin
          m_ev_e = fall;
          if (fall) m_cnt_e++;
          m_ev_i = (m_ps == 15);
          m_ps   = (m_ps + 1) % 16;
          if (m_ev_i) m_cnt_i++;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare, strobe tallies and internal-mode period capture
  // -------------------------------------------------------------------------
  int tl_e = 0, ts_e = 0, tv_e = 0;   // strobe tallies, external instance
  int cyc = 0;
  int last_len_i = -1, last_env_i = -1;
  int per_len_i = 0, per_env_i = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      begin
        int s_e, s_i;
        s_e = (m_cnt_e + 7) % 8;  // step that the last event executed
        s_i = (m_cnt_i + 7) % 8;
        chk("ext_step",  int'(step_e),  m_cnt_e % 8);
        chk("ext_len",   int'(len_e),   int'(m_ev_e && (s_e % 2 == 0)));
        chk("ext_sweep", int'(sweep_e), int'(m_ev_e && (s_e % 4 == 2)));
        chk("ext_env",   int'(env_e),   int'(m_ev_e && (s_e == 7)));
        chk("int_step",  int'(step_i),  m_cnt_i % 8);
        chk("int_len",   int'(len_i),   int'(m_ev_i && (s_i % 2 == 0)));
        chk("int_sweep", int'(sweep_i), int'(m_ev_i && (s_i % 4 == 2)));
        chk("int_env",   int'(env_i),   int'(m_ev_i && (s_i == 7)));
      end
      if (len_e)   tl_e++;
      if (sweep_e) ts_e++;
      if (env_e)   tv_e++;
      if (reset || !apu_enable) begin
        last_len_i = -1;
        last_env_i = -1;
      end else begin
        if (len_i) begin
          if (last_len_i >= 0) per_len_i = cyc - last_len_i;
          last_len_i = cyc;
        end
        if (env_i) begin
          if (last_env_i >= 0) per_env_i = cyc - last_env_i;
          last_env_i = cyc;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive(input logic d, input logic en);
    @(negedge clk);
    #1;
    div_apu_bit = d;
    apu_enable  = en;
  endtask

  task automatic fall_edge();
    repeat ($urandom_range(1, 3)) drive(1'b1, 1'b1);
    repeat ($urandom_range(1, 3)) drive(1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int b_l, b_s, b_v;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_step", int'(step_e), 0);
    chk("rst_strobes", int'({len_e, sweep_e, env_e}), 0);
    reset = 1'b0;
    apu_enable = 1'b1;

    // 1. eight edges: 4 length, 2 sweep, 1 envelope, back at step 0
    idle(2);
    b_l = tl_e; b_s = ts_e; b_v = tv_e;
    repeat (8) fall_edge();
    idle(2);
    chk("t1_len", tl_e - b_l, 4);
    chk("t1_sweep", ts_e - b_s, 2);
    chk("t1_env", tv_e - b_v, 1);
    chk("t1_step", int'(step_e), 0);

    // 2. sixty-four edges
    b_l = tl_e; b_s = ts_e; b_v = tv_e;
    repeat (64) fall_edge();
    idle(2);
    chk("t2_len", tl_e - b_l, 32);
    chk("t2_sweep", ts_e - b_s, 16);
    chk("t2_env", tv_e - b_v, 8);

    // 3. disable at step 5, re-enable, next event is step 0
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (5) fall_edge();
    idle(2);
    chk("t3_step5", int'(step_e), 5);
    repeat (3) drive(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("t3_step_off", int'(step_e), 0);
    drive(1'b0, 1'b1);
    idle(2);
    b_l = tl_e; b_s = ts_e; b_v = tv_e;
    fall_edge();
    idle(2);
    chk("t3_len", tl_e - b_l, 1);
    chk("t3_sweep", ts_e - b_s, 0);
    chk("t3_env", tv_e - b_v, 0);
    chk("t3_step", int'(step_e), 1);

    // 4. long high then long low: exactly one event
    repeat (100) drive(1'b1, 1'b1);
    repeat (100) drive(1'b0, 1'b1);
    chk("t4_step", int'(step_e), 2);

    // 5. async reset on the step-7 envelope strobe cycle
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (7) fall_edge();
    idle(2);
    chk("t5_step7", int'(step_e), 7);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("t5_env_hi", int'(env_e), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_env_rst", int'(env_e), 0);
    chk("t5_step_rst", int'(step_e), 0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;

    // 6. internal prescaler with div toggling randomly
    repeat (400) drive(1'($urandom_range(0, 1)), 1'b1);
    chk("t6_env_period", per_env_i, 128);
    chk("t6_len_period", per_len_i, 32);

    // Random inputs with occasional power-off, checked by the model
    repeat (800) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
